// File: rtl/out_serializer.sv
// Dual-channel frame serializer: a 2-deep pair buffer feeding L/R shift
// registers that stream WORD_W-bit frames MSB first, back to back when data waits.
module out_serializer #(
  parameter int WORD_W = 40
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic [WORD_W-1:0] DataL,
  input  logic [WORD_W-1:0] DataR,
  input  logic              DataValid,
  output logic              DataReady,
  output logic              OutReady,
  output logic              OutputL,
  output logic              OutputR,
  output logic              Overflow
);

  localparam int CntW = $clog2(WORD_W);
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q;
  logic [WORD_W-1:0] fifoL_q [2];
  logic [WORD_W-1:0] fifoR_q [2];
  logic              wrPtr_q;
  logic              rdPtr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic [WORD_W-1:0] shiftL_q;
  logic [WORD_W-1:0] shiftR_q;
  logic [CntW-1:0]   bitCnt_q;
  logic              outReady_q;
  logic              overflow_q;

  logic push;
  logic pop;
  logic drop;
  logic frameEnd;

  // A full buffer refuses writes even when the head leaves on the same edge.
  always_comb begin
    frameEnd = (state_q == SHIFT) && (bitCnt_q == '0);
    pop      = !Clear && (count_q != 2'd0) && ((state_q == IDLE) || frameEnd);
    push     = !Clear && DataValid && (count_q != 2'd2);
    drop     = !Clear && DataValid && (count_q == 2'd2);
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge Sclk) begin
    if (push) begin
      fifoL_q[wrPtr_q] <= DataL;
      fifoR_q[wrPtr_q] <= DataR;
    end
  end

  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      wrPtr_q    <= 1'b0;
      rdPtr_q    <= 1'b0;
      count_q    <= 2'd0;
      shiftL_q   <= '0;
      shiftR_q   <= '0;
      bitCnt_q   <= '0;
      outReady_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (Clear) begin
        state_q    <= IDLE;
        wrPtr_q    <= 1'b0;
        rdPtr_q    <= 1'b0;
        count_q    <= 2'd0;
        shiftL_q   <= '0;
        shiftR_q   <= '0;
        bitCnt_q   <= '0;
        outReady_q <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push) begin
          wrPtr_q <= ~wrPtr_q;
        end
        if (pop) begin
          rdPtr_q    <= ~rdPtr_q;
          shiftL_q   <= fifoL_q[rdPtr_q];
          shiftR_q   <= fifoR_q[rdPtr_q];
          bitCnt_q   <= LastBit;
          outReady_q <= 1'b1;
          state_q    <= SHIFT;
        end else begin
          case (state_q)
            IDLE: begin
              shiftL_q   <= '0;
              shiftR_q   <= '0;
              outReady_q <= 1'b0;
            end
            SHIFT: begin
              // Zeroing the shifters on frame end keeps the serial pins low while idle.
              if (bitCnt_q != '0) begin
                shiftL_q <= {shiftL_q[WORD_W-2:0], 1'b0};
                shiftR_q <= {shiftR_q[WORD_W-2:0], 1'b0};
                bitCnt_q <= bitCnt_q - 1'b1;
              end else begin
                shiftL_q   <= '0;
                shiftR_q   <= '0;
                outReady_q <= 1'b0;
                state_q    <= IDLE;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign DataReady = (count_q != 2'd2);
  assign OutReady  = outReady_q;
  assign OutputL   = shiftL_q[WORD_W-1];
  assign OutputR   = shiftR_q[WORD_W-1];
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_out_serializer.sv
// Randomized bench for out_serializer: a queue-based occupancy/timing model
// predicts handshakes, a falling-edge monitor rebuilds frames against a scoreboard.
module tb_out_serializer;

   localparam int W = 40;

   typedef struct packed {
      logic [W-1:0] l;
      logic [W-1:0] r;
   } pair_t;

   logic         Sclk = 1'b0;
   logic         Reset = 1'b0;
   logic         Clear = 1'b0;
   logic         DataValid = 1'b0;
   logic [W-1:0] DataL = '0;
   logic [W-1:0] DataR = '0;
   logic         DataReady;
   logic         OutReady;
   logic         OutputL;
   logic         OutputR;
   logic         Overflow;

   pair_t modelQ[$];
   pair_t scoreboard[$];
   int    bitsLeft = 0;
   bit    ovfModel = 1'b0;
   bit    flushPending = 1'b0;
   bit    monReset = 1'b0;
   int    testsRun = 0;
   int    failCount = 0;

   out_serializer #(.WORD_W(W)) dut (
      .Sclk(Sclk),
      .Reset(Reset),
      .Clear(Clear),
      .DataL(DataL),
      .DataR(DataR),
      .DataValid(DataValid),
      .DataReady(DataReady),
      .OutReady(OutReady),
      .OutputL(OutputL),
      .OutputR(OutputR),
      .Overflow(Overflow)
   );

   // Free-running serial clock.
   always #5 Sclk = ~Sclk;

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [W-1:0] randWord();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   // Drives one cycle of inputs, advances the model across the coming edge, then checks handshakes.
   task automatic applyStimulus(input bit valid, input bit clr, input logic [W-1:0] l, input logic [W-1:0] r);
      pair_t p;
      bit    popNow;
      bit    accept;
      DataValid = valid;
      Clear     = clr;
      DataL     = l;
      DataR     = r;
      if (clr) begin
         modelQ.delete();
         bitsLeft     = 0;
         flushPending = 1'b1;
      end else begin
         popNow = (bitsLeft <= 1) && (modelQ.size() > 0);
         accept = valid && (modelQ.size() < 2);
         if (valid && !accept) ovfModel = 1'b1;
         if (popNow) begin
            void'(modelQ.pop_front());
            bitsLeft = W;
         end else if (bitsLeft > 0) begin
            bitsLeft--;
         end
         if (accept) begin
            p.l = l;
            p.r = r;
            modelQ.push_back(p);
            scoreboard.push_back(p);
         end
      end
      @(posedge Sclk);
      #1;
      DataValid = 1'b0;
      Clear     = 1'b0;
      if (flushPending) begin
         scoreboard.delete();
         monReset     = 1'b1;
         flushPending = 1'b0;
      end
      checkOutput("DataReady", DataReady, modelQ.size() < 2);
      checkOutput("OutReady", OutReady, bitsLeft > 0);
      checkOutput("Overflow", Overflow, ovfModel);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
   endtask

   task automatic writePair(input logic [W-1:0] l, input logic [W-1:0] r);
      applyStimulus(1'b1, 1'b0, l, r);
   endtask

   // Asynchronous reset: outputs must drop before any clock edge arrives.
   task automatic doReset();
      Reset     = 1'b1;
      DataValid = 1'b0;
      Clear     = 1'b0;
      #1;
      checkOutput("ResetOutReady", OutReady, 1'b0);
      checkOutput("ResetOutputL", OutputL, 1'b0);
      checkOutput("ResetOutputR", OutputR, 1'b0);
      checkOutput("ResetOverflow", Overflow, 1'b0);
      checkOutput("ResetDataReady", DataReady, 1'b1);
      modelQ.delete();
      scoreboard.delete();
      bitsLeft = 0;
      ovfModel = 1'b0;
      monReset = 1'b1;
      repeat (2) @(posedge Sclk);
      #1;
      Reset = 1'b0;
   endtask

   // Monitor: rebuilds each frame from falling-edge samples and matches it with the scoreboard.
   initial begin
      logic [W-1:0] capL;
      logic [W-1:0] capR;
      pair_t        expPair;
      int           nbits;
      capL  = '0;
      capR  = '0;
      nbits = 0;
      forever begin
         @(negedge Sclk);
         if (monReset) begin
            nbits    = 0;
            monReset = 1'b0;
         end
         if (OutReady === 1'b1) begin
            capL = {capL[W-2:0], OutputL};
            capR = {capR[W-2:0], OutputR};
            nbits++;
            if (nbits == W) begin
               nbits = 0;
               testsRun++;
               if (scoreboard.size() == 0) begin
                  failCount++;
                  $display("[TB] FAIL frame: got L=%h R=%h, expected no frame at %0t", capL, capR, $time);
               end else begin
                  expPair = scoreboard.pop_front();
                  if (capL !== expPair.l || capR !== expPair.r) begin
                     failCount++;
                     $display("[TB] FAIL frame: got L=%h R=%h, expected L=%h R=%h at %0t",
                              capL, capR, expPair.l, expPair.r, $time);
                  end
               end
            end
         end else begin
            checkOutput("IdleOutputL", OutputL, 1'b0);
            checkOutput("IdleOutputR", OutputR, 1'b0);
            testsRun++;
            if (nbits != 0) begin
               failCount++;
               $display("[TB] FAIL frameLength: got %0d bits, expected %0d at %0t", nbits, W, $time);
               nbits = 0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      int r;
      #2;
      doReset();

      writePair(40'h80_0000_0001, 40'h00_0000_0003);
      idleCycles(45);

      for (int i = 0; i < 3; i++) writePair(randWord(), randWord());
      idleCycles(125);

      for (int i = 0; i < 4; i++) writePair(randWord(), randWord());
      idleCycles(3);
      applyStimulus(1'b0, 1'b1, '0, '0);
      idleCycles(45);

      writePair(randWord(), randWord());
      writePair(randWord(), randWord());
      guard = 0;
      while (bitsLeft != 1 && guard < 100) begin
         idleCycles(1);
         guard++;
      end
      writePair(40'hA5_5A5A_A55A, 40'h0F_F0F0_0FF0);
      idleCycles(90);

      writePair(randWord(), randWord());
      idleCycles(22);
      doReset();
      idleCycles(50);
      writePair(randWord(), randWord());
      idleCycles(45);

      writePair(randWord(), randWord());
      writePair(randWord(), randWord());
      idleCycles(10);
      applyStimulus(1'b1, 1'b1, randWord(), randWord());
      idleCycles(45);

      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 199);
         if (r < 2) applyStimulus($urandom_range(0, 1) == 1, 1'b1, randWord(), randWord());
         else if (r == 2) doReset();
         else applyStimulus(r < 60, 1'b0, randWord(), randWord());
      end
      idleCycles(130);
      checkOutput("ScoreboardDrained", scoreboard.size() == 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/out_serializer.md
OUT_SERIALIZER -- requirements
Module: out_serializer

Interface
REQ-001 SHALL have parameter: WORD_W, 40, width of each channel word and of each serial output frame.
REQ-002 SHALL have port: Sclk  input  1  serial output clock; all state updates on the rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Clear  input  1  synchronous abort; empties the buffer and stops the frame in progress.
REQ-005 SHALL have port: DataL  input  WORD_W  left-channel result word.
REQ-006 SHALL have port: DataR  input  WORD_W  right-channel result word.
REQ-007 SHALL have port: DataValid  input  1  one-cycle write strobe for the DataL/DataR pair.
REQ-008 SHALL have port: DataReady  output  1  high when the buffer holds fewer than 2 pairs.
REQ-009 SHALL have port: OutReady  output  1  high for every cycle in which OutputL/OutputR carry a valid frame bit.
REQ-010 SHALL have port: OutputL  output  1  left serial bit, MSB first.
REQ-011 SHALL have port: OutputR  output  1  right serial bit, MSB first.
REQ-012 SHALL have port: Overflow  output  1  sticky flag; a write was dropped.

Function
REQ-013 SHALL buffer word pairs in a 2-entry FIFO; DataReady = (count < 2), combinational from registered count.
REQ-014 SHALL accept the pair on a rising edge where DataValid=1 and DataReady=1; a write when DataReady=0 is dropped and sets Overflow, even if a pop occurs on the same edge.
REQ-015 SHALL use a 2-state FSM: IDLE and SHIFT.
REQ-016 In IDLE with count>0, SHALL pop the head pair into the L/R shift registers on the next edge and enter SHIFT.
REQ-017 Latency: a pair written at edge k into an empty buffer in IDLE SHALL appear at edge k+1: OutReady=1, OutputL=DataL[WORD_W-1], OutputR=DataR[WORD_W-1].
REQ-018 SHALL present one bit per Sclk cycle, MSB to LSB; outputs change only on rising edges, so they are stable at the falling edge where the consumer samples them.
REQ-019 SHALL keep OutReady high for exactly WORD_W consecutive cycles per frame, tracked by a bit counter from WORD_W-1 down to 0.
REQ-020 On the edge after bit 0, if count>0, SHALL pop the next pair and output its MSB with OutReady held high; frames are gap-free.
REQ-021 On the edge after bit 0, if count=0, SHALL return to IDLE with OutReady=0 and OutputL=OutputR=0.
REQ-022 FIFO read and write on the same edge SHALL leave count unchanged, and both pairs SHALL be preserved in order.
REQ-023 OutputL/OutputR SHALL be 0 whenever OutReady=0.
REQ-024 Clear=1 SHALL, on that edge, empty the FIFO, zero the shift registers and bit counter, force IDLE and OutReady=0, and ignore a coincident DataValid.
REQ-025 Clear SHALL NOT reset Overflow; only Reset clears it.

Reset
REQ-026 While Reset=1, independent of Sclk: OutReady=0, OutputL=0, OutputR=0, Overflow=0, FIFO count=0, DataReady=1, FSM=IDLE.
REQ-027 A frame interrupted by Reset SHALL be discarded, not resumed; after release, output starts only with the next accepted write.

Verification
REQ-028 Single frame: write L=40'h80_0000_0001, R=40'h00_0000_0003 at edge k -> OutReady high for edges k+1..k+40; OutputL=1 at k+1 and k+40, 0 between; OutputR=1 at k+39 and k+40; OutReady=0 at k+41.
REQ-029 Back-to-back: write three pairs, one per cycle, starting at edge k -> all three are accepted, with DataReady high throughout; OutReady stays high for 120 continuous cycles; a falling-edge capture returns all three pairs in order.
REQ-030 Overflow: two pairs buffered behind an active frame, then a third write -> DataReady=0, the third write is dropped, Overflow=1 and stays 1 after Clear.
REQ-031 Simultaneous pop/write: with count=1, issue DataValid on the edge that pops the head -> count stays 1 and the new pair is transmitted next.
REQ-032 Reset mid-frame: assert Reset after bit 20 of a frame -> outputs 0 immediately, asynchronously; after release with no writes, OutReady stays 0; the next write yields a full 40-bit frame.
REQ-033 Clear mid-frame with 1 pair buffered: assert Clear for 1 cycle -> OutReady=0 on the next edge; no further output until a new write.
